// File: rtl/collision_detector.sv
// Per-pixel collision detector: accumulates asteroid/bullet/ship overlaps over a
// frame and publishes them, with a saturating score, at each frame pulse.
module collision_detector #(
  parameter int ASTEROID_COUNT = 10,
  parameter int BULLET_COUNT   = 4,
  parameter int SCORE_W        = 16,
  parameter int POINTS         = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame,
  input  logic                      restart,
  input  logic [ASTEROID_COUNT-1:0] ast_drawing,
  input  logic [BULLET_COUNT-1:0]   bullet_drawing,
  input  logic                      ship_drawing,
  output logic [ASTEROID_COUNT-1:0] ast_shot,
  output logic [BULLET_COUNT-1:0]   bullet_kill,
  output logic                      ship_hit,
  output logic                      dead,
  output logic [SCORE_W-1:0]        score
);

  localparam int CNT_W = $clog2(ASTEROID_COUNT + 1);
  localparam int SUM_W = SCORE_W + 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic {S_RUN, S_DEAD} state_t;

  state_t                    r_state;
  logic [ASTEROID_COUNT-1:0] r_pend_ast;
  logic [BULLET_COUNT-1:0]   r_pend_bul;
  logic                      r_pend_ship;
  logic [ASTEROID_COUNT-1:0] r_ast_shot;
  logic [BULLET_COUNT-1:0]   r_bullet_kill;
  logic                      r_ship_hit;
  logic                      r_dead;
  logic [SCORE_W-1:0]        r_score;

  logic                      w_run;
  logic                      w_any_bullet;
  logic                      w_any_ast;
  logic [ASTEROID_COUNT-1:0] w_ast_hit;
  logic [BULLET_COUNT-1:0]   w_bul_hit;
  logic                      w_ship_hit;
  logic [CNT_W-1:0]          w_pop;
  logic [SUM_W-1:0]          w_sum;
  logic [SCORE_W-1:0]        w_score_next;

  assign w_run        = (r_state == S_RUN);
  assign w_any_bullet = |bullet_drawing;
  assign w_any_ast    = |ast_drawing;

  // Hit terms are masked while dead so nothing can accumulate.
  assign w_ast_hit  = (w_run && w_any_bullet) ? ast_drawing : '0;
  assign w_bul_hit  = (w_run && w_any_ast) ? bullet_drawing : '0;
  assign w_ship_hit = w_run & ship_drawing & w_any_ast;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < ASTEROID_COUNT; i++)
      w_pop = w_pop + CNT_W'(r_pend_ast[i]);
  end

  assign w_sum        = SUM_W'(r_score) + SUM_W'(POINTS) * SUM_W'(w_pop);
  assign w_score_next = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_pend_ast    <= '0;
      r_pend_bul    <= '0;
      r_pend_ship   <= 1'b0;
      r_ast_shot    <= '0;
      r_bullet_kill <= '0;
      r_ship_hit    <= 1'b0;
      r_dead        <= 1'b0;
      r_score       <= '0;
    end else if (restart) begin
      r_state       <= S_RUN;
      r_pend_ast    <= '0;
      r_pend_bul    <= '0;
      r_pend_ship   <= 1'b0;
      r_ast_shot    <= '0;
      r_bullet_kill <= '0;
      r_ship_hit    <= 1'b0;
      r_dead        <= 1'b0;
      r_score       <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (frame) begin
            r_ast_shot    <= r_pend_ast;
            r_bullet_kill <= r_pend_bul;
            r_ship_hit    <= r_pend_ship;
            r_score       <= w_score_next;
            if (r_pend_ship) begin
              // The death frame still publishes; pending state is dropped.
              r_state     <= S_DEAD;
              r_dead      <= 1'b1;
              r_pend_ast  <= '0;
              r_pend_bul  <= '0;
              r_pend_ship <= 1'b0;
            end else begin
              r_pend_ast  <= w_ast_hit;
              r_pend_bul  <= w_bul_hit;
              r_pend_ship <= w_ship_hit;
            end
          end else begin
            r_pend_ast  <= r_pend_ast | w_ast_hit;
            r_pend_bul  <= r_pend_bul | w_bul_hit;
            r_pend_ship <= r_pend_ship | w_ship_hit;
          end
        end
        S_DEAD: begin
          r_pend_ast  <= '0;
          r_pend_bul  <= '0;
          r_pend_ship <= 1'b0;
          r_dead      <= 1'b1;
          if (frame) begin
            r_ast_shot    <= '0;
            r_bullet_kill <= '0;
            r_ship_hit    <= 1'b0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign ast_shot    = r_ast_shot;
  assign bullet_kill = r_bullet_kill;
  assign ship_hit    = r_ship_hit;
  assign dead        = r_dead;
  assign score       = r_score;

endmodule

// File: tb/tb_collision_detector.sv
// Randomized and directed bench for collision_detector; a 16-bit and a 4-bit
// score instance share stimulus and are checked against a frame-level model.
module tb_collision_detector;

  localparam int NA = 10;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame = 1'b0;
  logic          restart = 1'b0;
  logic [NA-1:0] ast_drawing = '0;
  logic [NB-1:0] bullet_drawing = '0;
  logic          ship_drawing = 1'b0;

  logic [NA-1:0] ast_shot, ast_shot_s;
  logic [NB-1:0] bullet_kill, bullet_kill_s;
  logic          ship_hit, ship_hit_s, dead, dead_s;
  logic [15:0]   score;
  logic [3:0]    score_s;

  always #5 clk = ~clk;

  collision_detector #(.ASTEROID_COUNT(NA), .BULLET_COUNT(NB), .SCORE_W(16), .POINTS(1)) dut (
    .clk(clk), .rst(rst), .frame(frame), .restart(restart),
    .ast_drawing(ast_drawing), .bullet_drawing(bullet_drawing), .ship_drawing(ship_drawing),
    .ast_shot(ast_shot), .bullet_kill(bullet_kill), .ship_hit(ship_hit),
    .dead(dead), .score(score));

  collision_detector #(.ASTEROID_COUNT(NA), .BULLET_COUNT(NB), .SCORE_W(4), .POINTS(1)) dut_s (
    .clk(clk), .rst(rst), .frame(frame), .restart(restart),
    .ast_drawing(ast_drawing), .bullet_drawing(bullet_drawing), .ship_drawing(ship_drawing),
    .ast_shot(ast_shot_s), .bullet_kill(bullet_kill_s), .ship_hit(ship_hit_s),
    .dead(dead_s), .score(score_s));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: sets of hit objects gathered during the current
  // frame, the flags published for the previous frame, and integer scores.
  bit [NA-1:0] m_pend_ast, m_shot;
  bit [NB-1:0] m_pend_bul, m_kill;
  bit          m_pend_ship, m_hit, m_dead;
  int          m_score, m_score_s;

  function automatic void model_clear();
    m_pend_ast = '0; m_shot = '0; m_pend_bul = '0; m_kill = '0;
    m_pend_ship = 0; m_hit = 0; m_dead = 0; m_score = 0; m_score_s = 0;
  endfunction

  function automatic void model_step(bit f, bit r, bit [NA-1:0] ad, bit [NB-1:0] bd, bit sd);
    bit [NA-1:0] ah;
    bit [NB-1:0] bh;
    bit          sh;
    ah = (bd != 0) ? ad : '0;
    bh = (ad != 0) ? bd : '0;
    sh = sd && (ad != 0);
    if (r) begin
      model_clear();
    end else if (m_dead) begin
      if (f) begin
        m_shot = '0; m_kill = '0; m_hit = 0;
      end
    end else if (f) begin
      m_shot = m_pend_ast; m_kill = m_pend_bul; m_hit = m_pend_ship;
      m_score   = (m_score   + $countones(m_pend_ast) > 65535) ? 65535 : m_score   + $countones(m_pend_ast);
      m_score_s = (m_score_s + $countones(m_pend_ast) > 15)    ? 15    : m_score_s + $countones(m_pend_ast);
      if (m_pend_ship) begin
        m_dead = 1; m_pend_ast = '0; m_pend_bul = '0; m_pend_ship = 0;
      end else begin
        m_pend_ast = ah; m_pend_bul = bh; m_pend_ship = sh;
      end
    end else begin
      m_pend_ast |= ah; m_pend_bul |= bh; m_pend_ship |= sh;
    end
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".ast_shot"},    32'(ast_shot),      32'(m_shot));
    chk({ctx, ".bullet_kill"}, 32'(bullet_kill),   32'(m_kill));
    chk({ctx, ".ship_hit"},    32'(ship_hit),      32'(m_hit));
    chk({ctx, ".dead"},        32'(dead),          32'(m_dead));
    chk({ctx, ".score"},       32'(score),         32'(m_score));
    chk({ctx, ".score4"},      32'(score_s),       32'(m_score_s));
    chk({ctx, ".ast_shot4"},   32'(ast_shot_s),    32'(m_shot));
    chk({ctx, ".dead4"},       32'(dead_s),        32'(m_dead));
  endtask

  // Inputs are applied at the falling edge, consumed at the rising edge,
  // and outputs are compared at the following falling edge.
  task automatic tick(input bit f, input bit r, input bit [NA-1:0] ad,
                      input bit [NB-1:0] bd, input bit sd, input string ctx);
    frame = f; restart = r; ast_drawing = ad; bullet_drawing = bd; ship_drawing = sd;
    @(posedge clk);
    model_step(f, r, ad, bd, sd);
    @(negedge clk);
    check_all(ctx);
    frame = 0; restart = 0; ast_drawing = '0; bullet_drawing = '0; ship_drawing = 0;
  endtask

  task automatic idle(input int n, input string ctx);
    for (int k = 0; k < n; k++) tick(0, 0, '0, '0, 0, ctx);
  endtask

  task automatic do_frame(input string ctx);
    tick(1, 0, '0, '0, 0, ctx);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 0;

    // Idle frames
    for (int k = 0; k < 3; k++) begin
      idle(4, "idle");
      do_frame("idle_frame");
    end
    chk("idle.score", 32'(score), 0);

    // Single hit held for several pixels
    idle(2, "single");
    for (int k = 0; k < 5; k++) tick(0, 0, 10'b0000000100, 4'b0001, 0, "single_hit");
    idle(2, "single");
    do_frame("single_pub");
    chk("single.shot", 32'(ast_shot), 32'h004);
    chk("single.kill", 32'(bullet_kill), 32'h1);
    chk("single.score", 32'(score), 1);
    idle(5, "single_hold");
    do_frame("single_clear");
    chk("single.shot_clr", 32'(ast_shot), 0);
    chk("single.score_hold", 32'(score), 1);

    // Multi-hit plus overlap coincident with frame
    idle(2, "multi");
    tick(0, 0, 10'h001, 4'b0100, 0, "multi_a0");
    tick(0, 0, 10'h200, 4'b0100, 0, "multi_a9");
    idle(2, "multi");
    tick(1, 0, 10'h008, 4'b0001, 0, "multi_coinc");
    chk("multi.shot", 32'(ast_shot), 32'h201);
    chk("multi.score", 32'(score), 3);
    idle(3, "multi");
    do_frame("multi_next");
    chk("multi.shot3", 32'(ast_shot), 32'h008);
    chk("multi.score3", 32'(score), 4);

    // Ship hit, dead, restart
    idle(2, "ship");
    tick(0, 0, 10'h020, 4'b0000, 1, "ship_hit");
    tick(0, 0, 10'h002, 4'b0010, 0, "ship_ast");
    do_frame("ship_pub");
    chk("ship.hit", 32'(ship_hit), 1);
    chk("ship.dead", 32'(dead), 1);
    tick(0, 0, 10'h010, 4'b1000, 0, "dead_ovl");
    do_frame("dead_frame");
    chk("dead.shot", 32'(ast_shot), 0);
    chk("dead.score", 32'(score), 5);
    tick(0, 1, '0, '0, 0, "dead_restart");
    chk("restart.dead", 32'(dead), 0);
    chk("restart.score", 32'(score), 0);

    // Saturation on the 4-bit score instance
    for (int k = 0; k < 15; k++) begin
      tick(0, 0, 10'h001, 4'b0001, 0, "sat_hit");
      do_frame("sat_frame");
    end
    chk("sat.score4_15", 32'(score_s), 15);
    tick(0, 0, 10'h007, 4'b0010, 0, "sat_three");
    do_frame("sat_frame3");
    chk("sat.score4_hold", 32'(score_s), 15);
    chk("sat.score16", 32'(score), 18);

    // Restart coincident with frame
    tick(0, 0, 10'h040, 4'b0001, 0, "rf_pend");
    tick(1, 1, '0, '0, 0, "rf_both");
    chk("rf.shot", 32'(ast_shot), 0);
    chk("rf.score", 32'(score), 0);

    // Async reset mid-frame
    tick(0, 0, 10'h080, 4'b0001, 0, "ar_pend");
    do_frame("ar_pub");
    tick(0, 0, 10'h100, 4'b0001, 0, "ar_pend2");
    #2 rst = 1;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    rst = 0;
    do_frame("ar_after");
    chk("ar.shot", 32'(ast_shot), 0);

    // Randomized traffic
    begin
      int gap;
      gap = $urandom_range(6, 20);
      for (int c = 0; c < 4000; c++) begin
        bit          f, r, sd;
        bit [NA-1:0] ad;
        bit [NB-1:0] bd;
        f  = (gap == 0);
        ad = NA'($urandom & $urandom & $urandom);
        bd = NB'($urandom & $urandom);
        sd = ($urandom_range(0, 60) == 0);
        r  = (m_dead && $urandom_range(0, 7) == 0) || (f && $urandom_range(0, 15) == 0);
        tick(f, r, ad, bd, sd, "rand");
        gap = f ? $urandom_range(6, 20) : gap - 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
Downstream consumer of the per-asteroid `drawing` outputs, and of the bullet and ship sprite `drawing` strobes, on the shared raster. It detects per-pixel overlaps during a frame and accumulates them. At the next `frame` pulse it publishes one-frame-long `shot` flags back to each asteroid, bullet-kill flags, a ship-hit flag and a running score. A two-state run/dead FSM stops detection once the ship is hit.

Parameters:
ASTEROID_COUNT, 10, number of asteroid instances; width of the asteroid buses.
BULLET_COUNT, 4, number of bullet sprites; width of the bullet buses.
SCORE_W, 16, score counter width.
POINTS, 1, score added per asteroid hit.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame  in  1  one-cycle pulse at the start of vertical blank, same as the asteroid `frame`
restart  in  1  one-cycle pulse that leaves DEAD and clears the score
ast_drawing  in  ASTEROID_COUNT  bit i = asteroid i `drawing` for the current pixel
bullet_drawing  in  BULLET_COUNT  bit j = bullet j drawing the current pixel
ship_drawing  in  1  ship sprite drawing the current pixel
ast_shot  out  ASTEROID_COUNT  drives asteroid i `shot`; held for one full frame
bullet_kill  out  BULLET_COUNT  bullet j hit something last frame; held for one frame
ship_hit  out  1  ship collided last frame; held for one frame
dead  out  1  FSM is in DEAD
score  out  SCORE_W  accumulated score, saturating

Behaviour:
- Reset (async, rst=1): all outputs 0, all pending registers 0, FSM = RUN.
- Combinational hit terms, evaluated each cycle:
  - any_bullet = |bullet_drawing
  - ast_hit_c[i] = ast_drawing[i] & any_bullet
  - bul_hit_c[j] = bullet_drawing[j] & (|ast_drawing)
  - ship_hit_c = ship_drawing & (|ast_drawing)
  - Asteroid–asteroid overlap is ignored. Bullet–ship overlap is ignored.
- Pending registers: pend_ast, pend_bul, pend_ship.
  - In RUN, on a cycle without `frame`: pend |= hit_c (sticky OR). Latency: overlap at edge t is visible in pend at t+1.
  - On a `frame` cycle:
    - ast_shot <= pend_ast, bullet_kill <= pend_bul, ship_hit <= pend_ship.
    - pend <= hit_c of that same cycle. The coincident overlap counts toward the new frame and is not lost.
    - score <= sat(score + POINTS * popcount(pend_ast)).
  - Outputs are therefore stable from one `frame` edge to the next, so each asteroid samples `shot` once per frame.
- Score: add is computed at SCORE_W+8 bits, then clamped to 2^SCORE_W-1. Once at maximum, the score stays there and never wraps.
- FSM:
  - RUN -> DEAD on the `frame` cycle where pend_ship=1. That same edge still publishes ast_shot, ship_hit=1 and the score add.
  - In DEAD: hit_c is masked to 0 and pend is held at 0. On each `frame`: ast_shot, bullet_kill and ship_hit are loaded with 0; score is frozen; dead=1.
  - DEAD -> RUN on `restart`: score <= 0, pend <= 0, outputs <= 0, dead <= 0.
  - `restart` while in RUN: score <= 0 and pend <= 0; state unchanged.
  - `restart` and `frame` in the same cycle: `restart` wins; the frame publish is skipped and all outputs go to 0.
- `frame` with no overlaps in the prior frame: all flag outputs go to 0 and score is unchanged.
- rst asserted mid-frame: all state is cleared immediately, with no publish.
- Multiple pixels of the same overlap within a frame count as one hit per asteroid (sticky OR), so the score gets at most one add per asteroid per frame.

Test Plan:
- Reset then idle: rst pulse, 3 `frame` pulses with all inputs 0 -> all outputs 0, score=0, dead=0.
- Single hit: ast_drawing=10'b0000000100 and bullet_drawing=4'b0001 for 5 cycles mid-frame, then `frame` -> ast_shot=10'b0000000100 and bullet_kill=4'b0001 for exactly one frame, score=1; at the next `frame` both return to 0 and score stays 1.
- Multi-hit and coincidence: asteroids 0 and 9 each overlap bullet 2 in frame N; an overlap of asteroid 3 falls on the `frame` cycle itself -> after `frame`, ast_shot=10'b1000000001 and score=+2; asteroid 3's hit is published at the following `frame` (ast_shot=10'b0000001000, score=+1).
- Ship hit and DEAD: ship_drawing=1 with ast_drawing[5]=1, then `frame` -> ship_hit=1, dead=1; subsequent bullet/asteroid overlaps produce ast_shot=0 and no score change; `restart` -> dead=0, score=0.
- Saturation: SCORE_W=4, score driven to 15 via 15 single-hit frames, then a frame with 3 asteroid hits -> score stays 15.
- Restart/frame collision and async reset: `restart`=`frame`=1 with pend_ast nonzero -> outputs 0, score 0; rst asserted mid-frame with pend set -> outputs 0 on the same edge, and the next `frame` publishes 0.
